// File: rtl/nn_fixed_pkg.sv
// Shared definitions for fixed-point vector streaming blocks:
// the serializer state encoding and the index-width helper.
package nn_fixed_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_e;

    // Width of an element index for a vector of 'size' elements (clog2, min 1).
    function automatic int idx_width(input int size);
        if (size > 1) begin
            return $clog2(size);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/activation_vector_serializer_relu_clamp.sv
// relu_clamp: combinational per-element clamp of a signed vector.
// Negative elements become zero; non-negative elements pass unchanged.
// Only instantiated when SERIALIZER_RELU_EN is defined.
module relu_clamp #(
    parameter int WIDTH = 10,
    parameter int SIZE  = 32
) (
    input  logic signed [WIDTH-1:0] vec_i [SIZE],
    output logic signed [WIDTH-1:0] vec_o [SIZE]
);

    // Clamp each element on its sign bit.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            if (vec_i[i][WIDTH-1]) begin
                vec_o[i] = '0;
            end else begin
                vec_o[i] = vec_i[i];
            end
        end
    end

endmodule

// File: rtl/activation_vector_serializer.sv
// activation_vector_serializer: captures one parallel activation vector and
// streams its elements 0..SIZE-1 with index and last flag over valid/ready.
// A new vector may be captured on the last beat of the current one, so
// continuous traffic streams without bubbles.
// Optional feature macro: SERIALIZER_RELU_EN (clamp negatives to zero at capture).
module activation_vector_serializer
    import nn_fixed_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int NFRAC = 5,
    parameter  int SIZE  = 32,
    localparam int IDXW  = idx_width(SIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data [SIZE],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]         out_index,
    output logic                    out_last
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

    // NFRAC is carried only for interface consistency; reject impossible configs.
    if ((NFRAC > WIDTH) || (NFRAC < 0) || (SIZE < 2)) begin : g_bad_cfg
        $error("activation_vector_serializer: invalid WIDTH/NFRAC/SIZE");
    end

    ser_state_e              state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic                    last_q, last_d;
    logic signed [WIDTH-1:0] vec_q [SIZE];
    logic signed [WIDTH-1:0] cap_s [SIZE];
    logic                    capture_s;

`ifdef SERIALIZER_RELU_EN
    relu_clamp #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_relu_clamp (
        .vec_i (in_data),
        .vec_o (cap_s)
    );
`else
    // Without the clamp the captured value is the input element, bit-exact.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            cap_s[i] = in_data[i];
        end
    end
`endif

    // Accept a vector when idle, or on the final beat of the current one.
    assign in_ready  = (state_q == IDLE) |
                       ((state_q == STREAM) & last_q & out_ready);
    assign capture_s = in_valid & in_ready;

    assign out_valid = (state_q == STREAM);
    assign out_index = idx_q;
    assign out_last  = last_q;
    assign out_data  = vec_q[idx_q];

    // Next-state logic: index walk, last flag and back-to-back reload.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    last_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    last_d  = 1'b0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        if (in_valid) begin
                            state_d = STREAM;
                        end else begin
                            state_d = IDLE;
                        end
                        idx_d  = '0;
                        last_d = 1'b0;
                    end else begin
                        idx_d  = idx_q + IDXW'(1);
                        last_d = ((idx_q + IDXW'(1)) == LAST_IDX);
                    end
                end else begin
                    state_d = state_q;
                    idx_d   = idx_q;
                    last_d  = last_q;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Control registers; reset returns to IDLE at index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // Vector buffer: loaded only on an input handshake; reset wins over capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                vec_q[i] <= '0;
            end
        end else if (capture_s) begin
            for (int i = 0; i < SIZE; i++) begin
                vec_q[i] <= cap_s[i];
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                vec_q[i] <= vec_q[i];
            end
        end
    end

endmodule

// File: tb/tb_activation_vector_serializer.sv
// Self-checking bench for activation_vector_serializer (SIZE=4, WIDTH=10).
// Accepted vectors are expanded into expected beats in a queue; a monitor
// compares every presented beat and the handshake signals against it.
module tb_activation_vector_serializer;

    localparam int W = 10;
    localparam int S = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data [S];
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic [IW-1:0]       out_index;
    logic                out_last;

    activation_vector_serializer #(
        .WIDTH (W),
        .NFRAC (5),
        .SIZE  (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
        bit last;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference transform applied to a captured element.
    function automatic int ref_elem(input int v);
`ifdef SERIALIZER_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Model: observe handshake/reset mid-cycle, update the expectation at the edge.
    bit hs_s  = 1'b0;
    bit rst_s = 1'b0;
    int cap [S];
    always @(negedge clk) begin
        hs_s  = (in_valid === 1'b1) && (in_ready === 1'b1);
        rst_s = (reset === 1'b1);
        for (int i = 0; i < S; i++) cap[i] = int'(in_data[i]);
    end
    always @(posedge clk) begin
        beat_t b;
        if (rst_s) begin
            q.delete();
        end else if (hs_s) begin
            for (int i = 0; i < S; i++) begin
                b.data = ref_elem(cap[i]);
                b.idx  = i;
                b.last = (i == S - 1);
                q.push_back(b);
            end
        end
    end

    // Monitor: compare presented beat and handshake outputs against the queue.
    always @(negedge clk) begin
        int exp_rdy;
        if (mon_en) begin
            if (q.size() == 0) exp_rdy = 1;
            else exp_rdy = (q[0].last && out_ready) ? 1 : 0;
            chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
            chk("in_ready", int'(in_ready), exp_rdy);
            if (out_valid === 1'b1 && q.size() != 0) begin
                chk("out_data", int'(out_data), q[0].data);
                chk("out_index", int'(out_index), q[0].idx);
                chk("out_last", int'(out_last), int'(q[0].last));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int a, input int b, input int c, input int d);
        in_data[0] = W'(a);
        in_data[1] = W'(b);
        in_data[2] = W'(c);
        in_data[3] = W'(d);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_vec(0, 0, 0, 0);
        step(2);
        reset = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_last", int'(out_last), 0);
        mon_en = 1'b1;

        // Single vector, consecutive beats.
        set_vec(3, -2, 7, 0); in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        chk("first_beat_data", int'(out_data), 3);
        chk("first_beat_valid", int'(out_valid), 1);
        step(4);
        chk("idle_after_vec", int'(out_valid), 0);
        step(1);

        // Backpressure at idx=1 for 3 cycles.
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_data", int'(out_data), -2);
            chk("bp_hold_index", int'(out_index), 1);
            step(1);
        end
        out_ready = 1'b1;
        step(1);
        chk("bp_resume_data", int'(out_data), 7);
        step(3);

        // Back-to-back vectors with in_valid held high.
        set_vec(3, -2, 7, 0); in_valid = 1'b1;
        step(1);
        set_vec(1, 1, 1, 1);
        chk("b2b_ready_low", int'(in_ready), 0);
        step(3);
        chk("b2b_ready_pulse", int'(in_ready), 1);
        step(1);
        in_valid = 1'b0;
        chk("b2b_second_data", int'(out_data), 1);
        chk("b2b_second_index", int'(out_index), 0);
        chk("b2b_second_valid", int'(out_valid), 1);
        step(5);

        // Reset mid-stream at idx=2.
        set_vec(9, 8, 6, 5); in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(2);
        chk("pre_rst_index", int'(out_index), 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        step(3);

        // Sign / range extremes.
        set_vec(-1, 5, -512, 511); in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
`ifdef SERIALIZER_RELU_EN
        chk("clamp_beat0", int'(out_data), 0);
`else
        chk("clamp_beat0", int'(out_data), -1);
`endif
        step(6);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < S; i++) in_data[i] = W'($urandom);
            step(1);
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // Drain with a bounded wait.
        for (int c = 0; c < 40; c++) begin
            if (q.size() == 0 && out_valid == 1'b0) break;
            step(1);
        end
        chk("drain_empty", q.size(), 0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/activation_vector_serializer.md
# activation_vector_serializer

Converts one registered activation vector (SIZE signed fixed-point elements, as produced by the per-layer activation stage) into an element-serial stream with valid/ready handshaking on both sides. It sits between a parallel activation layer and any element-serial consumer, such as a streamed dense layer, an RNN recurrence input or an output FIFO. It is the unpacking end of the parallel-vector interface: it captures a full vector, then emits elements 0..SIZE-1 in order with an index and a last flag.

## Interface
- WIDTH, 10, total bits per fixed-point element
- NFRAC, 5, fractional bits (<= WIDTH); carried for consistency, no rescaling performed
- SIZE, 32, elements per vector (>= 2)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream vector valid
- in_ready  out  1  block can accept a vector this cycle
- in_data  in  signed [WIDTH-1:0] x [SIZE-1:0]  parallel activation vector
- out_valid  out  1  out_data/out_index/out_last valid
- out_ready  in  1  downstream accepts current element
- out_data  out  signed [WIDTH-1:0]  current element
- out_index  out  $clog2(SIZE)  index of current element
- out_last  out  1  current element is index SIZE-1

## Operation
- FSM states: IDLE, STREAM.
- IDLE: in_ready=1, out_valid=0. When in_valid is high, copy in_data into the internal buffer vec_q, clear idx to 0 and go to STREAM.
- STREAM: out_valid=1, out_data=vec_q[idx], out_index=idx, out_last=(idx==SIZE-1).
  - out_ready=1 and idx<SIZE-1: idx increments by 1.
  - out_ready=1 and idx==SIZE-1 (last beat): if in_valid, capture the new vector, set idx=0 and stay in STREAM (back-to-back, no bubble). Otherwise go to IDLE.
  - out_ready=0: all outputs hold stable (AXI-style). No change of data while valid is asserted and ready is low.
- in_ready = (state==IDLE) | (state==STREAM & out_last & out_ready). This is a combinational path from out_ready to in_ready and is permitted.
- in_data is sampled only on an input handshake. in_data changes at other times are ignored.
- No arithmetic beyond the optional clamp. Elements pass bit-exact.
- Reset: state=IDLE, idx=0, vec_q all zero. Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0.
- Reset mid-stream: the vector in progress is discarded and no further beats are emitted. Reset wins over a simultaneous handshake.

## Timing
- Latency: input handshake in cycle N, so element 0 is valid in cycle N+1.
- Throughput: one element per cycle with out_ready held high. A SIZE-element vector occupies SIZE cycles. Continuous vectors give 100% output utilisation.
- IDLE-path throughput: when IDLE is entered, one idle cycle elapses before the next vector can be accepted (accept cycle N, first beat N+1).
- All outputs are driven from registers except in_ready (state plus out_ready) and the out_data mux (a registered buffer indexed by a registered idx).

## Configuration
- SERIALIZER_RELU_EN defined: each element is clamped at capture. If the sign bit is 1 the stored value is 0; otherwise the element is stored unchanged. With this, the block can directly follow a dense layer that has no activation.
- SERIALIZER_RELU_EN undefined: elements are stored and emitted unchanged, including negatives.

## Structure
- Shared package nn_fixed_pkg holds:
  - serializer state enum (IDLE, STREAM);
  - the index-width helper function (clog2 of SIZE).
- WIDTH/NFRAC defaults stay module parameters, not package constants.
- One sub-module, relu_clamp (WIDTH, SIZE; combinational per-element clamp), is instantiated only under SERIALIZER_RELU_EN.

## Test plan
- Reset then idle: reset high 2 cycles -> in_ready=1, out_valid=0, out_data=0, out_index=0.
- Single vector, SIZE=4, in_data={3,-2,7,0}, out_ready=1 -> beats 3,-2,7,0 on consecutive cycles. out_index 0..3. out_last only on the beat with value 0. Then IDLE.
- Backpressure: out_ready low for 3 cycles at idx=1 -> out_data=-2 and out_index=1 held stable for all 3 cycles. Resumes with 7.
- Back-to-back: second vector {1,1,1,1} with in_valid held high -> in_ready pulses on the last beat of the first vector. Element 0 of the second vector follows the last beat with no gap.
- Reset mid-stream at idx=2 -> next cycle out_valid=0, in_ready=1, and no remaining beats appear.
- Macro on, in_data={-1,5,-512,511} (WIDTH=10) -> beats 0,5,0,511. Macro off -> beats -1,5,-512,511.
